// File: rtl/tcam_match_resolver.sv
// tcam_match_resolver
// Captures a TCAM match vector and streams the indices of all set bits,
// lowest index first, over a valid/ready handshake. An empty capture gives
// a one-cycle no_match pulse instead.
// Optional feature macro: MATCH_COUNT_EN. When it is defined, match_count
// holds the popcount of the last accepted capture. When it is undefined,
// match_count is tied to 0.
module tcam_match_resolver #(
    parameter  int MEMORY_SIZE = 20,
    localparam int IDX_W       = $clog2(MEMORY_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MEMORY_SIZE-1:0] match_in,
    input  logic                   start,
    input  logic                   flush,
    output logic [IDX_W-1:0]       out_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   no_match,
    output logic                   busy,
    output logic [IDX_W:0]         match_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [MEMORY_SIZE-1:0] r_pending;
    logic [MEMORY_SIZE-1:0] w_pending_next;
    logic                   r_no_match;
    logic                   w_no_match_next;

    logic [MEMORY_SIZE-1:0] w_capture;
    logic [IDX_W-1:0]       w_low_idx;
    logic                   w_one_left;
    logic                   w_accept_start;
    logic                   w_transfer;

    // Only a bit that is exactly 1 counts as a match; 0, X and Z are stored as 0.
    generate
        for (genvar gi = 0; gi < MEMORY_SIZE; gi++) begin : g_sanitize
            assign w_capture[gi] = (match_in[gi] === 1'b1);
        end
    endgenerate

    // Find the lowest set pending bit. The loop runs downward so that the lowest index is assigned last and wins.
    always_comb begin
        w_low_idx = '0;
        for (int i = MEMORY_SIZE - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    // Exactly one bit is left when the vector is nonzero and clearing its lowest set bit leaves zero.
    assign w_one_left = (r_pending != '0) &&
                        ((r_pending & (r_pending - MEMORY_SIZE'(1))) == '0);

    assign w_accept_start = (r_state == S_IDLE) && start && !flush;
    assign w_transfer     = (r_state == S_EMIT) && out_ready;

    // State, pending and no_match registers, cleared asynchronously by an active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_no_match <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pending  <= w_pending_next;
            r_no_match <= w_no_match_next;
        end
    end

    // Next-state logic. flush overrides both start and a transfer in the same cycle.
    always_comb begin
        w_state_next    = r_state;
        w_pending_next  = r_pending;
        w_no_match_next = 1'b0;
        if (flush) begin
            w_state_next   = S_IDLE;
            w_pending_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_pending_next = w_capture;
                        if (w_capture != '0) begin
                            w_state_next = S_EMIT;
                        end else begin
                            w_no_match_next = 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_transfer) begin
                        // Remove the lowest set bit, which is the index being accepted.
                        w_pending_next = r_pending & (r_pending - MEMORY_SIZE'(1));
                        if (w_one_left) begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_next   = S_IDLE;
                    w_pending_next = '0;
                end
            endcase
        end
    end

    assign out_valid = (r_state == S_EMIT);
    assign busy      = (r_state == S_EMIT);
    assign out_index = out_valid ? w_low_idx : '0;
    assign out_last  = out_valid ? w_one_left : 1'b0;
    assign no_match  = r_no_match;

`ifdef MATCH_COUNT_EN
    logic [IDX_W:0] r_match_count;
    logic [IDX_W:0] w_popcount;

    // Count the set bits of the sanitized capture vector.
    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < MEMORY_SIZE; i++) begin
            w_popcount = w_popcount + (IDX_W + 1)'(w_capture[i]);
        end
    end

    // Keep the popcount of the last accepted start. Only reset clears it; flush does not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_match_count <= '0;
        end else if (w_accept_start) begin
            r_match_count <= w_popcount;
        end
    end

    assign match_count = r_match_count;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_tcam_match_resolver.sv
// Self-checking bench for tcam_match_resolver. The bench pushes expected
// indices to a scoreboard queue when it drives start, and it pops each
// index when the DUT presents it.
module tb_tcam_match_resolver;

    localparam int MS = 20;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [MS-1:0] match_in = '0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_index;
    logic          out_valid;
    logic          out_last;
    logic          no_match;
    logic          busy;
    logic [IW:0]   match_count;

    typedef struct {
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    tcam_match_resolver #(.MEMORY_SIZE(MS)) dut (
        .clk         (clk),
        .reset       (reset),
        .match_in    (match_in),
        .start       (start),
        .flush       (flush),
        .out_index   (out_index),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .no_match    (no_match),
        .busy        (busy),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard model. Bits that are exactly 1 are expected, lowest first. The highest such bit is marked last.
    task automatic push_expected(input logic [MS-1:0] v);
        int hi;
        exp_t e;
        hi = -1;
        for (int i = 0; i < MS; i++) if (v[i] === 1'b1) hi = i;
        for (int i = 0; i < MS; i++) begin
            if (v[i] === 1'b1) begin
                e.idx  = IW'(i);
                e.last = (i == hi);
                sb.push_back(e);
            end
        end
    endtask

    // Expected match_count after an accepted start with vector v.
    function automatic logic [IW:0] exp_count(input logic [MS-1:0] v);
        logic [IW:0] c;
        c = '0;
`ifdef MATCH_COUNT_EN
        for (int i = 0; i < MS; i++) if (v[i] === 1'b1) c = c + 1'b1;
`endif
        return c;
    endfunction

    task automatic do_start(input logic [MS-1:0] v);
        match_in = v;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Hold out_ready high and compare each presented index with the scoreboard, one index per cycle.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() > 0 && n < budget) begin
            exp_t e;
            e = sb[0];
            checks++;
            if (out_valid !== 1'b1 || out_index !== e.idx || out_last !== e.last) begin
                failures++;
                $display("FAIL %s idx: got v=%0b i=%0d l=%0b exp v=1 i=%0d l=%0b",
                         name, out_valid, out_index, out_last, e.idx, e.last);
            end else begin
                $display("txn %s index=%0d last=%0b", name, out_index, out_last);
            end
            void'(sb.pop_front());
            step();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got %0d left exp 0", name, sb.size());
            sb.delete();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s end: got valid=%0b busy=%0b exp 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, out_index, out_last, no_match, busy, match_count} !== '0) begin
            failures++;
            $display("FAIL reset_state: got v=%0b i=%0d l=%0b nm=%0b b=%0b mc=%0d exp all 0",
                     out_valid, out_index, out_last, no_match, busy, match_count);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_no_match();
        do_start(20'h00000);
        checks++;
        if (no_match !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || match_count !== exp_count(20'h0)) begin
            failures++;
            $display("FAIL no_match_pulse: got nm=%0b v=%0b b=%0b mc=%0d exp 1 0 0 %0d",
                     no_match, out_valid, busy, match_count, exp_count(20'h0));
        end
        step();
        checks++;
        if (no_match !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL no_match_width: got nm=%0b v=%0b b=%0b exp 0 0 0", no_match, out_valid, busy);
        end
    endtask

    task automatic test_multi();
        out_ready = 1'b1;
        push_expected(20'h80005);
        do_start(20'h80005);
        drain("multi", 10);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push_expected(20'h00010);
        do_start(20'h00010);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_index !== 5'd4 || out_last !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_hold%0d: got v=%0b i=%0d l=%0b b=%0b exp 1 4 1 1",
                         c, out_valid, out_index, out_last, busy);
            end
            step();
        end
        drain("backpressure", 4);
    endtask

    task automatic test_start_ignored();
        exp_t e;
        out_ready = 1'b1;
        push_expected(20'h0000F);
        do_start(20'h0000F);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_index !== e.idx || out_last !== e.last) begin
            failures++;
            $display("FAIL ignore_first: got v=%0b i=%0d exp 1 %0d", out_valid, out_index, e.idx);
        end
        match_in = 20'hF0000;
        start    = 1'b1;
        step();
        start    = 1'b0;
        drain("start_ignored", 6);
        checks++;
        if (match_count !== exp_count(20'h0000F)) begin
            failures++;
            $display("FAIL ignore_count: got %0d exp %0d", match_count, exp_count(20'h0000F));
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        do_start(20'h0000F);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 5'd0) begin
            failures++;
            $display("FAIL flush_idx0: got v=%0b i=%0d exp 1 0", out_valid, out_index);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_index !== 5'd1 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL flush_idx1: got v=%0b i=%0d l=%0b exp 1 1 0", out_valid, out_index, out_last);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || no_match !== 1'b0 || out_index !== 5'd0) begin
            failures++;
            $display("FAIL flush_clear: got v=%0b b=%0b nm=%0b i=%0d exp 0 0 0 0",
                     out_valid, busy, no_match, out_index);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_stay: got v=%0b b=%0b exp 0 0", out_valid, busy);
        end
        // flush together with start in IDLE: the vector must not be captured.
        match_in = 20'h00001;
        start    = 1'b1;
        flush    = 1'b1;
        step();
        start    = 1'b0;
        flush    = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || no_match !== 1'b0) begin
            failures++;
            $display("FAIL flush_start: got v=%0b b=%0b nm=%0b exp 0 0 0", out_valid, busy, no_match);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        do_start(20'h000F0);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 5'd4) begin
            failures++;
            $display("FAIL areset_pre: got v=%0b i=%0d exp 1 4", out_valid, out_index);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_index, out_last, no_match, busy, match_count} !== '0) begin
            failures++;
            $display("FAIL areset_immediate: got v=%0b i=%0d l=%0b nm=%0b b=%0b mc=%0d exp all 0",
                     out_valid, out_index, out_last, no_match, busy, match_count);
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL areset_after: got v=%0b b=%0b exp 0 0", out_valid, busy);
        end
    endtask

    task automatic test_x_input();
        logic [MS-1:0] v;
        v    = 20'h00020;
        v[3] = 1'bx;
        out_ready = 1'b1;
        push_expected(v);
        do_start(v);
        drain("x_input", 6);
    endtask

    task automatic test_count_full();
        out_ready = 1'b1;
        push_expected(20'hFFFFF);
        do_start(20'hFFFFF);
        checks++;
        if (match_count !== exp_count(20'hFFFFF)) begin
            failures++;
            $display("FAIL count_full: got %0d exp %0d", match_count, exp_count(20'hFFFFF));
        end
        drain("full", 30);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        push_expected(20'h00003);
        do_start(20'h00003);
        drain("b2b_first", 5);
        push_expected(20'h40000);
        do_start(20'h40000);
        checks++;
        if (match_count !== exp_count(20'h40000)) begin
            failures++;
            $display("FAIL b2b_count: got %0d exp %0d", match_count, exp_count(20'h40000));
        end
        drain("b2b_second", 5);
    endtask

    initial begin
        test_reset();
        test_no_match();
        test_multi();
        test_backpressure();
        test_start_ignored();
        test_flush();
        test_async_reset();
        test_x_input();
        test_count_full();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcam_match_resolver.md
# tcam_match_resolver

Match-vector resolver sitting directly downstream of the TCAM array. Captures the per-entry match vector produced after a search and emits the indices of all matching entries, lowest index first, one per accepted transfer over a valid/ready handshake. Downstream consumers (action lookup, result logging) receive an index stream with an end-of-search marker, plus a one-cycle no-match indication for empty searches.

## Interface
- MEMORY_SIZE, 20: number of TCAM entries, i.e. width of the match vector.
- IDX_W, $clog2(MEMORY_SIZE): index width (derived, not overridden).

- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low.
- match_in  input  MEMORY_SIZE  TCAM match vector; bit i = entry i matched.
- start  input  1  capture match_in this cycle (asserted the cycle after the TCAM search register loads).
- flush  input  1  abort current search, discard pending matches.
- out_index  output  IDX_W  index of current match.
- out_valid  output  1  out_index/out_last valid.
- out_ready  input  1  consumer accepts current index.
- out_last  output  1  current index is the final match of this search.
- no_match  output  1  one-cycle pulse: captured vector was empty.
- busy  output  1  resolver holds unconsumed matches; start ignored.
- match_count  output  IDX_W+1  popcount of last captured vector (only with MATCH_COUNT_EN).

## Operation
- Internal pending register (MEMORY_SIZE bits), FSM states IDLE, EMIT.
- Capture: any match_in bit not exactly 1 (0, X, Z) is stored as 0.
- IDLE, start=1: pending <= sanitized match_in. Nonzero -> EMIT. Zero -> no_match=1 next cycle, remain IDLE.
- EMIT: out_valid=1, busy=1; out_index = lowest set bit of pending; out_last=1 iff exactly one bit set in pending.
- Transfer when out_valid & out_ready: clear that bit. If out_last -> IDLE (pending all zero); else stay EMIT, next-lowest index presented following cycle.
- out_valid low: out_index and out_last driven 0.
- start in EMIT: ignored, no capture, no error.
- flush=1: pending cleared, state IDLE, no_match 0, next cycle; priority over start and over a same-cycle transfer (that transfer still counts as accepted by consumer; no further indices).
- flush and start together in IDLE: flush wins, no capture.
- Highest-priority match = lowest index; bits >= MEMORY_SIZE do not exist.

## Timing
- Reset (async, active-low): pending=0, IDLE, out_valid=0, out_index=0, out_last=0, busy=0, no_match=0, match_count=0; takes effect immediately, independent of clk, including mid-EMIT.
- start at edge N -> out_valid (or no_match) high after edge N, i.e. visible in cycle N+1.
- Throughput: one index per cycle with out_ready held 1; K matches drain in K cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_index/out_last held stable.
- out_valid never drops without a transfer except by flush or reset.
- no_match exactly one cycle wide; busy = (state == EMIT).
- A new start is accepted in the cycle after the last transfer (busy=0), giving back-to-back searches with one idle cycle.

## Configuration
- MATCH_COUNT_EN defined: match_count register loaded with popcount of sanitized match_in on every accepted start (0 for empty vector), held until next accepted start; cleared by reset only, not by flush.
- MATCH_COUNT_EN undefined: no popcount logic; match_count port tied to 0.

## Test plan
- MEMORY_SIZE=20, match_in=20'h00000, start one cycle -> no_match=1 for exactly one cycle, out_valid stays 0, busy stays 0.
- match_in=20'h80005, start, out_ready=1 -> out_index 0, 2, 19 on three consecutive cycles, out_last only with 19, busy low the next cycle.
- match_in=20'h00010, out_ready=0 for 3 cycles then 1 -> out_index=4, out_valid=1, out_last=1 stable 3 cycles, transfer on 4th, then IDLE.
- match_in=20'h0000F streaming, start with 20'hF0000 during EMIT -> ignored, indices 0..3 only; second run: flush after index 1 accepted -> out_valid=0 next cycle, busy=0.
- Reset pulsed low asynchronously between edges mid-EMIT -> all outputs 0 immediately; match_in X on bit 3 with bit 5 set -> only index 5 emitted.
- MATCH_COUNT_EN defined, match_in=20'hFFFFF -> match_count=20 after capture, 20 indices 0..19 emitted; undefined build -> match_count=0.
